resp_misr_checker: RTL and testbench

- Response-side stage that sits directly downstream of the s9234 nominal/DFT pair.
- Each cycle it consumes the 39-bit nominal response and the 39-bit DFT response, compacts the DFT response into a 39-bit MISR signature, and counts mismatching patterns.
- It captures the first failing pattern index and its XOR difference vector.
- Replaces per-cycle text logging with an on-chip pass/fail summary for long runs (100000 patterns).

---
 rtl/resp_misr_checker.sv | 158 +++++++++++++++
 tb/tb_resp_misr_checker.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_misr_checker.sv
`default_nettype none
// ============================================================================
// Module      : resp_misr_checker
// Description : Compares the nominal and DFT response streams, compacts the
//               DFT responses into a MISR signature and keeps a pass/fail
//               summary (mismatch count, first failing index and difference).
//               Optional golden-signature compare: MISR_GOLDEN_CMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_misr_checker #(
    parameter int unsigned       WIDTH = 39,
    parameter int unsigned       CNT_W = 17,
    parameter logic [WIDTH-1:0]  TAPS  = 39'h00_0000_0010,
    parameter logic [WIDTH-1:0]  SEED  = 39'h0
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_pat,
    input  logic              resp_vld,
    input  logic [WIDTH-1:0]  nom_out,
    input  logic [WIDTH-1:0]  test_out,
    input  logic [WIDTH-1:0]  golden_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [WIDTH-1:0]  signature,
    output logic [CNT_W-1:0]  pat_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  first_idx,
`ifdef MISR_GOLDEN_CMP_EN
    output logic              sig_ok,
`endif
    output logic [WIDTH-1:0]  first_diff
);

    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_RUN      = 2'd1;
    localparam logic [1:0]       c_DONE     = 2'd2;
    // Bit 0 always takes the feedback, so its tap bit is not used.
    localparam logic [WIDTH-1:0] c_TAP_MASK = {TAPS[WIDTH-1:1], 1'b0};
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_num_pat;
    logic [WIDTH-1:0] r_sig;
    logic [CNT_W-1:0] r_pat_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [CNT_W-1:0] r_first_idx;
    logic [WIDTH-1:0] r_first_diff;
    logic             r_first_seen;
    logic             r_pass;

    logic [WIDTH-1:0] w_diff;
    logic             w_mismatch;
    logic [WIDTH-1:0] w_sig_next;
    logic [CNT_W-1:0] w_pat_next;
    logic [CNT_W-1:0] w_fail_next;
    logic             w_pass_final;
    logic             w_pass_empty;

    assign w_diff      = nom_out ^ test_out;
    assign w_mismatch  = |w_diff;
    assign w_sig_next  = {r_sig[WIDTH-2:0], r_sig[WIDTH-1]} ^ test_out
                       ^ (c_TAP_MASK & {WIDTH{r_sig[WIDTH-1]}});
    assign w_pat_next  = r_pat_cnt + c_CNT_ONE;
    assign w_fail_next = (w_mismatch && (r_fail_cnt != c_CNT_MAX))
                       ? r_fail_cnt + c_CNT_ONE : r_fail_cnt;

`ifdef MISR_GOLDEN_CMP_EN
    assign w_pass_final = (w_fail_next == '0) && (w_sig_next == golden_sig);
    assign w_pass_empty = (SEED == golden_sig);
`else
    logic w_unused_golden;
    assign w_unused_golden = ^golden_sig;
    assign w_pass_final    = (w_fail_next == '0);
    assign w_pass_empty    = 1'b1;
`endif

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            r_state      <= c_IDLE;
            r_num_pat    <= '0;
            r_sig        <= SEED;
            r_pat_cnt    <= '0;
            r_fail_cnt   <= '0;
            r_first_idx  <= '0;
            r_first_diff <= '0;
            r_first_seen <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_num_pat    <= num_pat;
                        r_sig        <= SEED;
                        r_pat_cnt    <= '0;
                        r_fail_cnt   <= '0;
                        r_first_idx  <= '0;
                        r_first_diff <= '0;
                        r_first_seen <= 1'b0;
                        if (num_pat == '0) begin
                            r_state <= c_DONE;
                            r_pass  <= w_pass_empty;
                        end else begin
                            r_state <= c_RUN;
                            r_pass  <= 1'b0;
                        end
                    end
                end
                c_RUN: begin
                    if (resp_vld) begin
                        r_sig      <= w_sig_next;
                        r_pat_cnt  <= w_pat_next;
                        r_fail_cnt <= w_fail_next;
                        if (w_mismatch && !r_first_seen) begin
                            r_first_seen <= 1'b1;
                            r_first_idx  <= r_pat_cnt;
                            r_first_diff <= w_diff;
                        end
                        // Final absorb enters DONE with the verdict on the same edge.
                        if (w_pat_next == r_num_pat) begin
                            r_state <= c_DONE;
                            r_pass  <= w_pass_final;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef MISR_GOLDEN_CMP_EN
    logic r_sig_ok;

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            r_sig_ok <= 1'b0;
        end else begin
            r_sig_ok <= (r_sig == golden_sig);
        end
    end

    assign sig_ok = r_sig_ok;
`endif

    assign busy       = (r_state == c_RUN);
    assign done       = (r_state == c_DONE);
    assign pass       = r_pass;
    assign signature  = r_sig;
    assign pat_cnt    = r_pat_cnt;
    assign fail_cnt   = r_fail_cnt;
    assign first_idx  = r_first_idx;
    assign first_diff = r_first_diff;

endmodule
`default_nettype wire

// File: tb/tb_resp_misr_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_resp_misr_checker
// Description : Randomised self-checking bench for resp_misr_checker against
//               a pattern-level reference model. Honours MISR_GOLDEN_CMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_resp_misr_checker;

    localparam int         W       = 39;
    localparam int         CW      = 17;
    localparam logic [W-1:0] c_TAPS = 39'h00_0000_0010;
    localparam logic [W-1:0] c_SEED = 39'h0;

    logic          CK;
    logic          RSTN;
    logic          start;
    logic [CW-1:0] num_pat;
    logic          resp_vld;
    logic [W-1:0]  nom_out;
    logic [W-1:0]  test_out;
    logic [W-1:0]  golden_sig;
    logic          busy;
    logic          done;
    logic          pass;
    logic [W-1:0]  signature;
    logic [CW-1:0] pat_cnt;
    logic [CW-1:0] fail_cnt;
    logic [CW-1:0] first_idx;
    logic [W-1:0]  first_diff;
`ifdef MISR_GOLDEN_CMP_EN
    logic          sig_ok;
`endif

    resp_misr_checker #(
        .WIDTH (W),
        .CNT_W (CW),
        .TAPS  (c_TAPS),
        .SEED  (c_SEED)
    ) u_dut (
        .CK         (CK),
        .RSTN       (RSTN),
        .start      (start),
        .num_pat    (num_pat),
        .resp_vld   (resp_vld),
        .nom_out    (nom_out),
        .test_out   (test_out),
        .golden_sig (golden_sig),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .pat_cnt    (pat_cnt),
        .fail_cnt   (fail_cnt),
        .first_idx  (first_idx),
`ifdef MISR_GOLDEN_CMP_EN
        .sig_ok     (sig_ok),
`endif
        .first_diff (first_diff)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    int checks = 0;
    int errors = 0;

    // Stimulus for one run: patterns in order, plus a per-cycle valid pattern.
    logic [W-1:0] q_nom[$];
    logic [W-1:0] q_tst[$];
    bit           q_vld[$];

    // Reference results of the last run.
    logic [W-1:0]  e_sig;
    logic [CW-1:0] e_pat;
    logic [CW-1:0] e_fail;
    logic [CW-1:0] e_fidx;
    logic [W-1:0]  e_fdiff;
    bit            e_seen;
    bit            e_pass;
    int            m_early_done;
    int            m_hold_bad;

    function automatic logic [W-1:0] rand_w();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[W-1:0];
    endfunction

    // One MISR clock written straight from the bit-level rule.
    function automatic logic [W-1:0] misr_step(input logic [W-1:0] s, input logic [W-1:0] d);
        logic [W-1:0] n;
        logic         fb;
        fb = s[W-1];
        for (int i = 0; i < W; i++) begin
            if (i == 0) n[i] = d[0] ^ fb;
            else        n[i] = d[i] ^ s[i-1] ^ (c_TAPS[i] & fb);
        end
        return n;
    endfunction

    task automatic model_absorb(input logic [W-1:0] nom, input logic [W-1:0] tst);
        e_sig = misr_step(e_sig, tst);
        if (nom != tst) begin
            if (!e_seen) begin
                e_seen  = 1'b1;
                e_fidx  = e_pat;
                e_fdiff = nom ^ tst;
            end
            if (e_fail != {CW{1'b1}}) e_fail = e_fail + 1;
        end
        e_pat = e_pat + 1;
    endtask

    task automatic model_verdict();
`ifdef MISR_GOLDEN_CMP_EN
        e_pass = (e_fail == 0) && (e_sig == golden_sig);
`else
        e_pass = (e_fail == 0);
`endif
    endtask

    // Starts a run of n patterns and plays the queued stimulus; returns at the
    // negedge after the final absorb, with start deasserted.
    task automatic play_run(input int n, input bit noisy);
        int           k;
        int           c;
        bit           v;
        logic [W-1:0] prev;
        @(negedge CK);
        start    = 1'b1;
        num_pat  = CW'(n);
        resp_vld = 1'b0;
        nom_out  = rand_w();
        test_out = rand_w();
        e_sig = c_SEED; e_pat = 0; e_fail = 0; e_fidx = 0; e_fdiff = 0; e_seen = 1'b0;
        m_early_done = 0;
        m_hold_bad   = 0;
        @(posedge CK); #1;
        k = 0;
        c = 0;
        while (k < n) begin
            @(negedge CK);
            v = (c < q_vld.size()) ? q_vld[c] : 1'b1;
            c++;
            start    = noisy && ($urandom_range(0, 3) == 0);
            num_pat  = CW'($urandom_range(0, 50));
            resp_vld = v;
            if (v) begin
                nom_out  = q_nom[k];
                test_out = q_tst[k];
            end else begin
                nom_out  = rand_w();
                test_out = rand_w();
            end
            prev = signature;
            @(posedge CK); #1;
            if (v) begin
                model_absorb(q_nom[k], q_tst[k]);
                k++;
            end
            if (k < n && done) m_early_done++;
            if (!v && signature !== prev) m_hold_bad++;
        end
        @(negedge CK);
        start    = 1'b0;
        resp_vld = 1'b0;
        if (n == 0) begin
`ifdef MISR_GOLDEN_CMP_EN
            e_pass = (c_SEED == golden_sig);
`else
            e_pass = 1'b1;
`endif
        end else begin
            model_verdict();
        end
    endtask

    task automatic clear_q();
        q_nom.delete();
        q_tst.delete();
        q_vld.delete();
    endtask

    task automatic test_reset();
        RSTN = 1'b0; start = 1'b0; num_pat = '0; resp_vld = 1'b0;
        nom_out = '0; test_out = '0; golden_sig = '0;
        repeat (3) @(posedge CK);
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            errors++; $display("FAIL reset_flags: busy/done/pass=%b%b%b want 000", busy, done, pass); end
        checks++; if (signature !== c_SEED) begin
            errors++; $display("FAIL reset_sig: got %h want %h", signature, c_SEED); end
        checks++; if (pat_cnt !== '0 || fail_cnt !== '0 || first_idx !== '0) begin
            errors++; $display("FAIL reset_cnt: pat %0d fail %0d idx %0d want 0", pat_cnt, fail_cnt, first_idx); end
        checks++; if (first_diff !== '0) begin
            errors++; $display("FAIL reset_diff: got %h want 0", first_diff); end
`ifdef MISR_GOLDEN_CMP_EN
        checks++; if (sig_ok !== 1'b0) begin
            errors++; $display("FAIL reset_sig_ok: got %b want 0", sig_ok); end
`endif
        @(negedge CK);
        RSTN = 1'b1;
    endtask

    task automatic test_single();
        clear_q();
        golden_sig = 39'h1;
        q_nom.push_back(39'h1); q_tst.push_back(39'h1);
        play_run(1, 1'b0);
        checks++; if (signature !== 39'h1 || pat_cnt !== 1) begin
            errors++; $display("FAIL single_sig: sig %h pat %0d want 1 1", signature, pat_cnt); end
        checks++; if (done !== 1'b1 || pass !== 1'b1 || fail_cnt !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_done: done %b pass %b fail %0d busy %b want 1 1 0 0", done, pass, fail_cnt, busy); end
    endtask

    task automatic test_shift_feedback();
        clear_q();
        golden_sig = 39'h11;
        q_nom.push_back(39'h40_0000_0000); q_tst.push_back(39'h40_0000_0000);
        q_nom.push_back(39'h0);            q_tst.push_back(39'h0);
        play_run(2, 1'b0);
        checks++; if (signature !== 39'h11) begin
            errors++; $display("FAIL feedback_sig: got %h want 11", signature); end
        checks++; if (pass !== 1'b1 || done !== 1'b1) begin
            errors++; $display("FAIL feedback_pass: pass %b done %b want 1 1", pass, done); end
    endtask

    task automatic test_first_fail();
        logic [W-1:0] v;
        clear_q();
        for (int i = 0; i < 5; i++) begin
            v = rand_w();
            q_nom.push_back(v);
            q_tst.push_back((i == 3) ? (v ^ 39'h5) : v);
        end
        play_run(5, 1'b0);
        checks++; if (fail_cnt !== 1 || first_idx !== 3) begin
            errors++; $display("FAIL first_fail_idx: fail %0d idx %0d want 1 3", fail_cnt, first_idx); end
        checks++; if (first_diff !== 39'h5 || pass !== 1'b0) begin
            errors++; $display("FAIL first_fail_diff: diff %h pass %b want 5 0", first_diff, pass); end
        checks++; if (signature !== e_sig) begin
            errors++; $display("FAIL first_fail_sig: got %h want %h", signature, e_sig); end
    endtask

    task automatic test_valid_gaps();
        bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        clear_q();
        for (int i = 0; i < 7; i++) q_vld.push_back(pat[i]);
        for (int i = 0; i < 4; i++) begin
            q_nom.push_back(rand_w());
            q_tst.push_back(q_nom[i]);
        end
        play_run(4, 1'b0);
        checks++; if (m_early_done != 0 || m_hold_bad != 0) begin
            errors++; $display("FAIL gaps_hold: early_done %0d hold_changes %0d want 0 0", m_early_done, m_hold_bad); end
        checks++; if (pat_cnt !== 4 || done !== 1'b1 || signature !== e_sig) begin
            errors++; $display("FAIL gaps_end: pat %0d done %b sig %h want 4 1 %h", pat_cnt, done, signature, e_sig); end
    endtask

    task automatic test_reset_mid_run();
        @(negedge CK);
        start = 1'b1; num_pat = 4;
        @(negedge CK);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resp_vld = 1'b1; nom_out = rand_w(); test_out = rand_w();
            @(negedge CK);
        end
        resp_vld = 1'b0;
        checks++; if (busy !== 1'b1 || pat_cnt !== 2) begin
            errors++; $display("FAIL midrun_busy: busy %b pat %0d want 1 2", busy, pat_cnt); end
        RSTN = 1'b0;
        @(negedge CK);
        RSTN = 1'b1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || signature !== c_SEED) begin
            errors++; $display("FAIL midrun_reset_state: busy %b done %b pass %b sig %h want 0 0 0 %h", busy, done, pass, signature, c_SEED); end
        checks++; if (pat_cnt !== 0 || fail_cnt !== 0 || first_idx !== 0 || first_diff !== 0) begin
            errors++; $display("FAIL midrun_reset_cnt: pat %0d fail %0d idx %0d diff %h want 0", pat_cnt, fail_cnt, first_idx, first_diff); end
        // Stays idle with nothing started.
        @(negedge CK);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midrun_idle: busy %b done %b want 0 0", busy, done); end
        golden_sig = c_SEED;
        clear_q();
        play_run(0, 1'b0);
        checks++; if (done !== 1'b1 || pass !== e_pass || pat_cnt !== 0) begin
            errors++; $display("FAIL empty_run: done %b pass %b pat %0d want 1 %b 0", done, pass, pat_cnt, e_pass); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v;
        clear_q();
        for (int i = 0; i < 6; i++) begin
            v = rand_w();
            q_nom.push_back(v);
            q_tst.push_back((i == 1 || i == 4) ? (v ^ (39'h1 << i)) : v);
        end
        play_run(6, 1'b1);
        checks++; if (fail_cnt !== 2 || first_idx !== 1 || first_diff !== 39'h2 || pass !== 1'b0) begin
            errors++; $display("FAIL b2b_first: fail %0d idx %0d diff %h pass %b want 2 1 2 0", fail_cnt, first_idx, first_diff, pass); end
        clear_q();
        for (int i = 0; i < 3; i++) begin
            q_nom.push_back(rand_w());
            q_tst.push_back(q_nom[i]);
        end
        play_run(3, 1'b1);
        checks++; if (fail_cnt !== 0 || first_idx !== 0 || first_diff !== 0 || pat_cnt !== 3) begin
            errors++; $display("FAIL b2b_second: fail %0d idx %0d diff %h pat %0d want 0 0 0 3", fail_cnt, first_idx, first_diff, pat_cnt); end
        checks++; if (signature !== e_sig || pass !== e_pass) begin
            errors++; $display("FAIL b2b_sig: sig %h pass %b want %h %b", signature, pass, e_sig, e_pass); end
    endtask

    task automatic test_random();
        int n;
        int mism_pct;
        logic [W-1:0] v;
        for (int r = 0; r < 20; r++) begin
            clear_q();
            n        = $urandom_range(1, 40);
            mism_pct = (r % 3 == 0) ? 0 : $urandom_range(1, 30);
            golden_sig = rand_w();
            for (int c = 0; c < 2 * n; c++) q_vld.push_back($urandom_range(0, 3) != 0);
            for (int i = 0; i < n; i++) begin
                v = rand_w();
                q_nom.push_back(v);
                q_tst.push_back(($urandom_range(0, 99) < mism_pct) ? (v ^ (39'h1 << $urandom_range(0, W - 1))) : v);
            end
            play_run(n, r[0]);
            checks++; if (signature !== e_sig || pat_cnt !== e_pat) begin
                errors++; $display("FAIL rand_sig run %0d: sig %h pat %0d want %h %0d", r, signature, pat_cnt, e_sig, e_pat); end
            checks++; if (fail_cnt !== e_fail || first_idx !== e_fidx || first_diff !== e_fdiff) begin
                errors++; $display("FAIL rand_fail run %0d: fail %0d idx %0d diff %h want %0d %0d %h", r, fail_cnt, first_idx, first_diff, e_fail, e_fidx, e_fdiff); end
            checks++; if (done !== 1'b1 || pass !== e_pass || m_early_done != 0 || m_hold_bad != 0) begin
                errors++; $display("FAIL rand_done run %0d: done %b pass %b early %0d hold %0d want 1 %b 0 0", r, done, pass, m_early_done, m_hold_bad, e_pass); end
        end
    endtask

`ifdef MISR_GOLDEN_CMP_EN
    task automatic test_golden();
        for (int g = 0; g < 2; g++) begin
            clear_q();
            golden_sig = (g == 0) ? 39'h11 : 39'h12;
            q_nom.push_back(39'h40_0000_0000); q_tst.push_back(39'h40_0000_0000);
            q_nom.push_back(39'h0);            q_tst.push_back(39'h0);
            play_run(2, 1'b0);
            @(negedge CK);
            checks++; if (sig_ok !== (g == 0) || pass !== (g == 0) || fail_cnt !== 0) begin
                errors++; $display("FAIL golden %0d: sig_ok %b pass %b fail %0d want %b %b 0", g, sig_ok, pass, fail_cnt, g == 0, g == 0); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_shift_feedback();
        test_first_fail();
        test_valid_gaps();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
`ifdef MISR_GOLDEN_CMP_EN
        test_golden();
`endif
        repeat (2) @(negedge CK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
